// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: branch/jump resolve, data-memory handshake, MEM/WB register
// Optional access timeout/abort enabled by defining MEM_STAGE_TIMEOUT_EN.
module mem_stage #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_Jump,
  input  logic        in_Branch,
  input  logic        in_MemRead,
  input  logic        in_MemWrite,
  input  logic        in_MemtoReg,
  input  logic        in_RegWrite,
  input  logic [27:0] in_JumpAddress,
  input  logic [31:0] in_AddFour,
  input  logic [31:0] in_Adder,
  input  logic        in_Zero,
  input  logic [31:0] in_ALU,
  input  logic [31:0] in_ReadData2,
  input  logic [4:0]  in_WriteRegister,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        out_Stall,
  output logic        out_PCSrc,
  output logic [31:0] out_PCTarget,
  output logic        out_RegWrite,
  output logic        out_MemtoReg,
  output logic [31:0] out_ReadData,
  output logic [31:0] out_ALU,
`ifdef MEM_STAGE_TIMEOUT_EN
  output logic        out_MemErr,
`endif
  output logic [4:0]  out_WriteRegister
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t state, state_nxt;
  logic   access_req;
  logic   latch_req;
  logic   ack_done;
  logic   timeout_hit;
  logic   unused_addfour;

  assign access_req     = in_MemRead | in_MemWrite;
  assign unused_addfour = ^in_AddFour[27:0];

  assign out_PCSrc    = in_Jump | (in_Branch & in_Zero);
  assign out_PCTarget = in_Jump ? {in_AddFour[31:28], in_JumpAddress} : in_Adder;

  // The request is held in ACCESS from the latched copy; upstream is frozen by out_Stall.
  assign mem_req = (state == ACCESS);

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tmo_cnt;

  assign timeout_hit = (state == ACCESS) && !mem_ack && (tmo_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || state != ACCESS) begin
      tmo_cnt <= '0;
    end else if (!mem_ack) begin
      tmo_cnt <= tmo_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_MemErr <= 1'b0;
    end else begin
      out_MemErr <= timeout_hit;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT;
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    out_Stall = 1'b0;
    latch_req = 1'b0;
    ack_done  = 1'b0;
    case (state)
      IDLE: begin
        if (access_req) begin
          out_Stall = 1'b1;
          latch_req = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          ack_done  = 1'b1;
          state_nxt = IDLE;
        end else if (timeout_hit) begin
          state_nxt = IDLE;
        end else begin
          out_Stall = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Nothing may be held while the stage is being reset.
    if (rst) begin
      out_Stall = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      mem_we            <= 1'b0;
      mem_addr          <= '0;
      mem_wdata         <= '0;
      out_RegWrite      <= 1'b0;
      out_MemtoReg      <= 1'b0;
      out_ReadData      <= '0;
      out_ALU           <= '0;
      out_WriteRegister <= '0;
    end else begin
      state <= state_nxt;
      if (latch_req) begin
        mem_addr  <= in_ALU;
        mem_wdata <= in_ReadData2;
        mem_we    <= in_MemWrite;
      end
      // Stalled or aborted cycles retire as bubbles; other fields follow the inputs.
      out_RegWrite      <= in_RegWrite & ~out_Stall & ~timeout_hit;
      out_MemtoReg      <= in_MemtoReg;
      out_ALU           <= in_ALU;
      out_WriteRegister <= in_WriteRegister;
      if (ack_done && !mem_we) begin
        out_ReadData <= mem_rdata;
      end
    end
  end

endmodule
